// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
// Data-memory request/acknowledge port used by the memory stage.
//   master : the pipeline stage (drives request, consumes response)
//   slave  : the data memory (consumes request, drives response)
// Signals:
//   mem_req   request valid, held high until ack or abandon
//   mem_we    1 = store, 0 = load
//   mem_addr  byte address
//   mem_wdata store data
//   mem_rdata load data, valid with mem_ack
//   mem_ack   response strobe
interface mem_access_stage_if #(
    parameter int N = 32
);
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory stage between the EX/MEM and MEM/WB pipeline registers. Non-memory
// instructions pass straight through combinationally. Loads and stores run
// one request/acknowledge transaction on the data-memory port, stalling
// upstream and emitting bubbles downstream until the result is ready.
// Ports:
//   clk, rst            clock, async active-high reset
//   i_valid_E ..        instruction fields from the EX/MEM register
//   o_stall_M           upstream must hold its instruction
//   o_regw_M ..         fields for the MEM/WB register
//   o_fault_M           one-cycle pulse when an access was abandoned
//   dmem                data-memory port (master side)
//
// state | meaning
// IDLE  | pass-through, or accept a new access
// WAIT  | request outstanding, counting cycles without ack
// DONE  | present latched result for one cycle, then back to IDLE
module mem_access_stage #(
    parameter int N       = 32,
    parameter int M       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid_E,
    input  logic         i_regw_E,
    input  logic         i_regmem_E,
    input  logic         i_memw_E,
    input  logic [M-1:0] i_regScr_E,
    input  logic [N-1:0] i_ALUrslt_E,
    input  logic [N-1:0] i_wdata_E,
    output logic         o_stall_M,
    output logic         o_regw_M,
    output logic         o_regmem_M,
    output logic [M-1:0] o_regScr_M,
    output logic [N-1:0] o_ALUrslt_M,
    output logic [N-1:0] o_readdata_M,
    output logic         o_fault_M,
    mem_access_stage_if.master dmem
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic          r_regw;
    logic          r_regmem;
    logic          r_memw;
    logic [M-1:0]  r_regscr;
    logic [N-1:0]  r_addr;
    logic [N-1:0]  r_wdata;
    logic [N-1:0]  r_rdata;
    logic          r_fault;
    logic [CW-1:0] r_cnt;

    logic          w_acc;
    logic [CW-1:0] w_cnt_inc;
    logic          w_timeout;

    assign w_acc     = i_valid_E & (i_regmem_E | i_memw_E);
    assign w_cnt_inc = r_cnt + CW'(1);
    // Counter holds the number of completed no-ack WAIT cycles, so the
    // TIMEOUT-th such cycle is the last one.
    assign w_timeout = (w_cnt_inc == TO_CNT);

    assign dmem.mem_addr  = r_addr;
    assign dmem.mem_wdata = r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regw   <= 1'b0;
            r_regmem <= 1'b0;
            r_memw   <= 1'b0;
            r_regscr <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_regw   <= i_regw_E;
                        r_regmem <= i_regmem_E;
                        // A load+store combination is treated as a load.
                        r_memw   <= i_memw_E & ~i_regmem_E;
                        r_regscr <= i_regScr_E;
                        r_addr   <= i_ALUrslt_E;
                        r_wdata  <= i_wdata_E;
                        r_rdata  <= '0;
                        r_fault  <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                ST_WAIT: begin
                    if (dmem.mem_ack) begin
                        r_rdata <= r_memw ? '0 : dmem.mem_rdata;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_timeout) begin
                            r_rdata <= '0;
                            r_fault <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_fault <= 1'b0;
                end
                default: begin
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_stall_M    = 1'b0;
        o_regw_M     = 1'b0;
        o_regmem_M   = 1'b0;
        o_regScr_M   = '0;
        o_ALUrslt_M  = '0;
        o_readdata_M = '0;
        o_fault_M    = 1'b0;
        dmem.mem_req = 1'b0;
        dmem.mem_we  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    o_stall_M    = 1'b1;
                    w_state_next = ST_WAIT;
                end else if (i_valid_E) begin
                    o_regw_M    = i_regw_E;
                    o_regScr_M  = i_regScr_E;
                    o_ALUrslt_M = i_ALUrslt_E;
                end
            end
            ST_WAIT: begin
                dmem.mem_req = 1'b1;
                dmem.mem_we  = r_memw;
                o_stall_M    = 1'b1;
                if (dmem.mem_ack || w_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // The same instruction is still on the _E inputs here, so
                // acc is deliberately ignored in this state.
                o_regw_M     = r_regw;
                o_regmem_M   = r_regmem;
                o_regScr_M   = r_regscr;
                o_ALUrslt_M  = r_addr;
                o_readdata_M = r_rdata;
                o_fault_M    = r_fault;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Pass-through is combinational, so reset must mask it explicitly.
        if (rst) begin
            o_stall_M    = 1'b0;
            o_regw_M     = 1'b0;
            o_regmem_M   = 1'b0;
            o_regScr_M   = '0;
            o_ALUrslt_M  = '0;
            o_readdata_M = '0;
            o_fault_M    = 1'b0;
            dmem.mem_req = 1'b0;
            dmem.mem_we  = 1'b0;
        end
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the 5-stage pipeline, between the execute/memory pipeline register and the memory-writeback pipeline register. Non-memory instructions pass through in zero cycles. Loads and stores run a request/acknowledge transaction on a variable-latency data-memory port. While a transaction is pending the block stalls upstream stages and drives bubbles downstream. It produces the `regw_M`, `regmem_M`, `regScr_M`, `ALUrslt_M` and `readdata_M` values captured by the writeback register.

## Interface
- `N`, 32, data and address width
- `M`, 4, register-specifier width
- `TIMEOUT`, 16, maximum `WAIT` cycles without `mem_ack` before the access is abandoned (≥1)

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `valid_E` in 1: instruction present from the execute/memory register
- `regw_E` in 1: register-write flag
- `regmem_E` in 1: load; writeback selects memory data
- `memw_E` in 1: store
- `regScr_E` in M: destination register
- `ALUrslt_E` in N: ALU result, which is the address for loads and stores
- `wdata_E` in N: store data
- `stall_M` out 1: upstream must hold its instruction this cycle
- `regw_M`, `regmem_M` out 1: to the writeback register
- `regScr_M` out M, `ALUrslt_M` out N, `readdata_M` out N: to the writeback register
- `fault_M` out 1: one-cycle pulse when an access timed out
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out N, `mem_wdata` out N: data-memory request
- `mem_rdata` in N, `mem_ack` in 1: data-memory response

## Operation
- An access is `acc = valid_E & (regmem_E | memw_E)`. If `regmem_E` and `memw_E` are both high, the access is treated as a load (`mem_we=0`).
- The FSM has three states, `IDLE`, `WAIT` and `DONE`. The reset state is `IDLE`.

`IDLE`:
- Without `acc`, the outputs are combinational pass-through of the `_E` inputs, gated by `valid_E`:
  - `regw_M = valid_E & regw_E`, `regmem_M = 0`.
  - `regScr_M` and `ALUrslt_M` are passed through; `readdata_M = 0`.
  - `stall_M = 0`.
- With `acc`:
  - `stall_M = 1`.
  - Downstream outputs form a bubble: `regw_M = regmem_M = 0`, all data outputs 0.
  - At the clock edge, latch `regw`, `regmem`, `memw`, `regScr`, address and `wdata`; clear the timeout counter; go to `WAIT`.

`WAIT`:
- `mem_req = 1`. `mem_we`, `mem_addr` and `mem_wdata` come from the latched values and are stable for the whole state.
- `stall_M = 1`; downstream outputs are a bubble.
- If `mem_ack` is high, latch `mem_rdata` (a store latches 0) and go to `DONE`.
- Otherwise the counter increments. When it reaches `TIMEOUT` with no ack, latch readdata = 0, set the fault flag, and go to `DONE`.

`DONE`:
- `mem_req = 0`, `stall_M = 0`.
- Outputs come from the latched values:
  - `regw_M`, `regmem_M`, `regScr_M` as latched.
  - `ALUrslt_M` = latched address.
  - `readdata_M` = latched read data.
- On timeout, `fault_M = 1` for this cycle only. A timed-out load still writes 0 to its destination.
- The same instruction is still on the `_E` inputs in this cycle and must not start a new access.
- Unconditionally return to `IDLE`; upstream advances at this edge.

`mem_ack` outside `WAIT` is ignored, including a late ack after a timeout.

## Timing
- Reset values, while `rst` is high and in the cycle after deassertion:
  - State `IDLE`; latches and counter 0.
  - `mem_req`, `mem_we`, `fault_M`, `stall_M` = 0.
  - All downstream outputs forced to 0 while `rst` is high.
- Non-memory instruction: zero added latency; `stall_M` never rises.
- Memory access with `mem_ack` in the k-th `WAIT` cycle (k ≥ 1):
  - `stall_M` is high for k+1 cycles.
  - Real outputs appear in cycle k+1 after acceptance (in `DONE`) and are captured by the writeback register at the end of that cycle.
  - The minimum total is 3 cycles.
- Timeout: `WAIT` lasts exactly `TIMEOUT` cycles; `fault_M` pulses in the following `DONE` cycle.
- Back-to-back accesses: after `DONE`, a new `acc` is detected in the next `IDLE` cycle, so there are no idle bubbles beyond `DONE`.
- Reset asserted mid-`WAIT`: `mem_req` drops immediately (asynchronous), the access is abandoned, no outputs are produced, and a subsequent ack is ignored.
- The counter width is `$clog2(TIMEOUT+1)`; it does not wrap, because the state is left when the counter equals `TIMEOUT`.

## Test plan
- ALU op (`valid_E=1`, `regw_E=1`, `regScr_E=4'h3`, `ALUrslt_E=32'h0000_0010`): same-cycle `regw_M=1`, `regScr_M=3`, `ALUrslt_M=0x10`, `readdata_M=0`, `stall_M=0`.
- Load from address 0x100, ack in the 1st `WAIT` cycle with `mem_rdata=0xDEADBEEF`:
  - `stall_M` high for 2 cycles; `mem_req` high for 1 cycle with `mem_addr=0x100`, `mem_we=0`.
  - In the `DONE` cycle: `regmem_M=1`, `readdata_M=0xDEADBEEF`.
- Store of 0xCAFEF00D to 0x200, ack after 5 cycles:
  - `mem_we=1`, and `mem_addr`/`mem_wdata` stable for all 5 cycles.
  - `stall_M` high for 6 cycles; `DONE` shows `regw_M=0`; bubbles downstream throughout.
- Load with no ack, `TIMEOUT=16`:
  - `mem_req` high for exactly 16 cycles.
  - `DONE` shows `readdata_M=0` and a single-cycle `fault_M` pulse.
  - An ack injected 2 cycles later causes no change.
- Two consecutive loads, each acked in its 1st `WAIT` cycle: `mem_req` pulses for 1 cycle each, separated by exactly 2 cycles; both results appear in order.
- `rst` raised in the 3rd `WAIT` cycle of a load: `mem_req` falls the same cycle; after release, state is `IDLE`, all outputs are 0, and `fault_M` never pulses.
